// File: rtl/deco_pulse_if.sv
// deco_pulse_if: code push handshake and one-hot strobe bus for deco_pulse.
interface deco_pulse_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic          En;
    logic          in_valid;
    logic [2:0]    in_code;
    logic          in_ready;
    logic [7:0]    o;
    logic          o_valid;
    logic          busy;
    logic [LW-1:0] level;
    modport master (
        output En, in_valid, in_code,
        input  in_ready, o, o_valid, busy, level
    );
    modport slave (
        input  En, in_valid, in_code,
        output in_ready, o, o_valid, busy, level
    );
endinterface

// File: rtl/deco_pulse.sv
// deco_pulse: queued 3-to-8 one-hot decoder holding each strobe PULSE_LEN cycles.
// Define DECO_GAP_EN to insert one all-zero cycle between consecutive strobes.
module deco_pulse #(
    parameter int PULSE_LEN  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    deco_pulse_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef DECO_GAP_EN
    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
`else
    typedef enum logic {IDLE, DRIVE} state_t;
`endif
    state_t      state;
    logic [3:0]  cnt;
    logic [7:0]  o_q;
    logic [2:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, level;
    logic        empty, full, push, load;
    assign level = wr_ptr - rd_ptr;
    assign empty = level == '0;
    assign full  = level == (AW+1)'(FIFO_DEPTH);
    assign push  = bus.in_valid && !full;
    // a pop happens whenever the FSM is ready for a new strobe and En allows progress
`ifdef DECO_GAP_EN
    assign load = bus.En && !empty && state != DRIVE;
`else
    assign load = bus.En && !empty && (state == IDLE || cnt == 4'd0);
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            o_q    <= 8'h00;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= bus.in_code;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                o_q    <= 8'b1 << mem[rd_ptr[AW-1:0]];
                cnt    <= 4'(PULSE_LEN - 1);
                state  <= DRIVE;
            end else if (bus.En) begin
                if (state == DRIVE) begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        o_q <= 8'h00;
`ifdef DECO_GAP_EN
                        state <= GAP;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef DECO_GAP_EN
                else if (state == GAP) begin
                    state <= IDLE;
                end
`endif
            end
        end
    end
    assign bus.in_ready = !full;
    assign bus.o        = bus.En ? o_q : 8'h00;
    assign bus.o_valid  = |bus.o;
    assign bus.busy     = state != IDLE || !empty;
    assign bus.level    = level;
endmodule

// File: tb/tb_deco_pulse.sv
// tb_deco_pulse: directed vector table plus hand-written sequences for deco_pulse.
module tb_deco_pulse;
    localparam int PL = 2;
`ifdef DECO_GAP_EN
    localparam bit G = 1'b1;
`else
    localparam bit G = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;
    logic [2:0] seq [8];
    always #5 clk = ~clk;
    deco_pulse_if #(.FIFO_DEPTH(4)) bus ();
    deco_pulse_if #(.FIFO_DEPTH(4)) bus4 ();
    deco_pulse #(.PULSE_LEN(PL), .FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    deco_pulse #(.PULSE_LEN(4), .FIFO_DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    typedef struct {
        logic       en;
        logic       valid;
        logic [2:0] code;
        logic [7:0] o;
        logic       busy;
        logic [2:0] level;
        logic       ready;
    } vec_t;
    vec_t vt [13];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // expected strobe at cycle c for seq[0..n-1] issued back-to-back after lead zero cycles
    function automatic logic [7:0] exp_o(input int c, input int n, input int lead);
        int t, s, r;
        logic [7:0] one;
        one = 8'h01;
        t = c - lead;
        if (t < 0) return 8'h00;
        s = t / (PL + int'(G));
        r = t % (PL + int'(G));
        if (s < n && r < PL) return one << seq[s];
        return 8'h00;
    endfunction
    task automatic run_seq(input string name, input int n, input int lead, input int cycles, input bit push);
        int  idx;
        bit  acc;
        bit  seen_full;
        idx = 0;
        seen_full = 0;
        for (int c = 0; c < cycles; c++) begin
            if (push && idx < n) begin
                bus.in_valid = 1'b1;
                bus.in_code  = seq[idx];
                acc = bus.in_ready;
            end else begin
                bus.in_valid = 1'b0;
                acc = 1'b0;
            end
            tick();
            if (acc) idx++;
            chk({name, "_o"}, 32'(bus.o), 32'(exp_o(c, n, lead)));
            if (push && bus.level == 3'd4) begin
                seen_full = 1;
                chk({name, "_ready_full"}, 32'(bus.in_ready), 32'd0);
            end
        end
        bus.in_valid = 1'b0;
        if (push) chk({name, "_reached_full"}, 32'(seen_full), 32'd1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        bus.En = 1'b1; bus.in_valid = 1'b0; bus.in_code = 3'd0;
        bus4.En = 1'b1; bus4.in_valid = 1'b0; bus4.in_code = 3'd0;
        vt[0]  = '{1'b1, 1'b1, 3'd5, 8'h00, 1'b1, 3'd1, 1'b1};
        vt[1]  = '{1'b1, 1'b0, 3'd0, 8'h20, 1'b1, 3'd0, 1'b1};
        vt[2]  = '{1'b1, 1'b0, 3'd0, 8'h20, 1'b1, 3'd0, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 3'd0, 8'h00, G,    3'd0, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 3'd1, 8'h00, 1'b1, 3'd1, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 3'd2, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 3'd3, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b1, 3'd4, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 3'd6, 8'h00, 1'b1, 3'd4, 1'b0};
        vt[10] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b0};
        vt[11] = '{1'b1, 1'b0, 3'd0, 8'h02, 1'b1, 3'd3, 1'b1};
        vt[12] = '{1'b1, 1'b0, 3'd0, 8'h02, 1'b1, 3'd3, 1'b1};
        tick();
        tick();
        chk("rst_o", 32'(bus.o), 32'h00);
        chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 13; i++) begin
            bus.En       = vt[i].en;
            bus.in_valid = vt[i].valid;
            bus.in_code  = vt[i].code;
            tick();
            chk($sformatf("vec%0d_o", i), 32'(bus.o), 32'(vt[i].o));
            chk($sformatf("vec%0d_o_valid", i), 32'(bus.o_valid), 32'(vt[i].o != 8'h00));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vt[i].busy));
            chk($sformatf("vec%0d_level", i), 32'(bus.level), 32'(vt[i].level));
            chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(vt[i].ready));
        end
        bus.in_valid = 1'b0;
        seq[0] = 3'd2; seq[1] = 3'd3; seq[2] = 3'd4;
        run_seq("drain", 3, int'(G), 3 * (PL + int'(G)) + 2, 1'b0);
        chk("drain_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 8; i++) seq[i] = 3'(7 - i);
        run_seq("stream", 8, 1, 1 + 8 * (PL + int'(G)) + 2, 1'b1);
        chk("stream_busy", 32'(bus.busy), 32'd0);
        bus.En = 1'b0;
        bus.in_valid = 1'b1; bus.in_code = 3'd5; tick();
        bus.in_code = 3'd6; tick();
        chk("pp_level_pre", 32'(bus.level), 32'd2);
        bus.En = 1'b1; bus.in_code = 3'd7; tick();
        bus.in_valid = 1'b0;
        chk("pp_level", 32'(bus.level), 32'd2);
        chk("pp_o_first", 32'(bus.o), 32'h20);
        tick();
        chk("pp_o_hold", 32'(bus.o), 32'h20);
        seq[0] = 3'd6; seq[1] = 3'd7;
        run_seq("pp_order", 2, int'(G), 2 * (PL + int'(G)) + 2, 1'b0);
        chk("pp_busy", 32'(bus.busy), 32'd0);
        bus.En = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_code = 3'(i + 1); tick();
        end
        bus.in_valid = 1'b0;
        bus.En = 1'b1; tick();
        chk("rmid_drive_o", 32'(bus.o), 32'h02);
        chk("rmid_drive_level", 32'(bus.level), 32'd3);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rmid_o", 32'(bus.o), 32'h00);
        chk("rmid_level", 32'(bus.level), 32'd0);
        chk("rmid_ready", 32'(bus.in_ready), 32'd1);
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rmid_stale%0d", i), 32'(bus.o), 32'h00);
        end
        bus4.in_valid = 1'b1; bus4.in_code = 3'd2; tick();
        bus4.in_valid = 1'b0;
        chk("endrop_push_o", 32'(bus4.o), 32'h00);
        tick();
        chk("endrop_first", 32'(bus4.o), 32'h04);
        bus4.En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("endrop_low%0d_o", i), 32'(bus4.o), 32'h00);
            chk($sformatf("endrop_low%0d_busy", i), 32'(bus4.busy), 32'd1);
        end
        bus4.En = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("endrop_resume%0d", i), 32'(bus4.o), 32'h04);
        end
        tick();
        chk("endrop_end", 32'(bus4.o), 32'h00);
        tick();
        chk("endrop_idle", 32'(bus4.busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/deco_pulse.md
# deco_pulse

Registered 3-to-8 one-hot decoder with an input queue and a programmable strobe width. It is the receive-side counterpart of the 8-to-3 priority encoder `enco`. Upstream logic pushes 3-bit codes through a valid/ready handshake. The block replays each code in order as a one-hot strobe on an 8-bit bus, holding each strobe for a fixed number of cycles. An enable input gates the bus and freezes sequencing.

## Interface
- `PULSE_LEN`, 2: cycles each one-hot strobe stays asserted; legal range 1..15.
- `FIFO_DEPTH`, 4: input queue depth; power of two, 2..16.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `En`  in  1  enable; low forces `o` to zero and freezes the state machine and pulse counter.
- `in_valid`  in  1  `in_code` is valid this cycle.
- `in_code`  in  3  code to decode; bit index of the strobe.
- `in_ready`  out  1  queue can accept a code; equals not-full.
- `o`  out  8  registered one-hot strobe, or 8'h00.
- `o_valid`  out  1  high whenever `o` is non-zero.
- `busy`  out  1  high when the state is not IDLE or the queue is non-empty.
- `level`  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

## Operation
- **Push:** a code is written when `in_valid && in_ready` at a rising edge. A push is independent of `En`.
- **Full queue:** `in_ready` is 0 when full, even if a pop happens in the same cycle. The queue never over- or under-flows.
- **States:**
  - IDLE: `o`=0. If `En` is 1 and the queue is non-empty, pop the head, load `o <= 8'b1 << head`, load the counter with `PULSE_LEN-1`, and go to DRIVE.
  - DRIVE: `o` holds. With `En`=1, the counter decrements each cycle. At counter 0, go to GAP if `DECO_GAP_EN` is defined, otherwise go to IDLE-equivalent reload. Reload means: if the queue is non-empty, pop the next code, load `o` and the counter, and stay in DRIVE; otherwise clear `o` and go to IDLE.
  - GAP (only when `DECO_GAP_EN` is defined): `o`=0 for exactly one enabled cycle, then behave as IDLE.
- **En low:**
  - `o` output is forced to 8'h00 combinationally after the register.
  - State, counter and queue head are held.
  - When `En` returns high, the interrupted strobe resumes with its remaining count.
- **Simultaneous push and pop:** both take effect and `level` is unchanged.
- **Reset:** applies at the clock edge and overrides everything, including mid-strobe. Reset values: state IDLE, queue empty, `level`=0, `o`=8'h00, `o_valid`=0, `busy`=0, `in_ready`=1. Queued codes are discarded.
- **Counter and pointers:** the counter is 4 bits. Queue pointers wrap modulo `FIFO_DEPTH`, with an extra bit to distinguish full from empty.

## Timing
- **Latency** (queue empty, IDLE, `En`=1): a code pushed at edge N is popped at edge N+1. `o` is non-zero from edge N+1 to edge N+1+`PULSE_LEN`.
- **Throughput:** one code per `PULSE_LEN` cycles without `DECO_GAP_EN`, or per `PULSE_LEN`+1 cycles with it.
- **Back-to-back codes without the gap:** `o` changes directly from one one-hot value to the next, with no zero cycle.
- **`in_ready` after a pop from a full queue:** it rises in the cycle after the pop edge.
- **`level`, `busy`, `in_ready`:** all are registered-state derived, with no combinational path from `in_valid`.

## Configuration
- `DECO_GAP_EN`:
  - Defined: the GAP state is compiled in. Consecutive strobes are separated by exactly one all-zero cycle.
  - Undefined: there is no GAP state and strobes are back-to-back.
  - Both builds are identical in every other respect.

## Test plan
- **Reset then single code:** release `rst` and push code 3'd5 at edge N with `PULSE_LEN`=2. Expect `o`=8'b00100000 after edges N+1 and N+2, `o`=0 after N+3, and `busy`=0 after N+3.
- **Stream of 8 codes:** push 7,6,5,4,3,2,1,0 as fast as `in_ready` allows.
  - Expect `o` to sequence 8'h80, 8'h40 … 8'h01, each for 2 cycles.
  - Without `DECO_GAP_EN`, expect no zero cycle between strobes; with it, expect exactly one zero cycle between strobes.
  - Expect `in_ready`=0 whenever `level`=4.
- **Full queue:** hold `En`=0 and push 5 codes. Expect 4 accepted, `level`=4, `in_ready`=0, and `o`=0 throughout. Raise `En` and expect the first code strobed on the next edge.
- **En drop mid-strobe:** with `PULSE_LEN`=4 and code 3'd2, drop `En` after 1 strobe cycle for 3 cycles. Expect `o`=0 during the drop and 3 further cycles of 8'h04 after `En` returns.
- **Reset mid-operation:** assert `rst` for one edge while in DRIVE with 3 codes queued. Expect `o`=0, `level`=0, `in_ready`=1 and `busy`=0 after that edge, and no stale strobe afterwards.
- **Simultaneous push/pop:** push on the same edge the FSM pops with `level`=2. Expect `level` to stay 2 and the order of codes to be preserved.
